// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//
// Sequencing controller placed in front of the Hangman game handler. It turns
// raw keyboard events into clean load/load_x strobes, picks the round's word
// from a free-running counter, filters repeated letters, watches the handler's
// game_state for a win or loss, keeps a saturating win score and holds the
// result for HOLD_CYCLES clocks before going back to idle.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   key_valid     one-cycle key event pulse
//   key_code      0..25 letter A..Z, 26 start, 27..31 ignored
//   game_state    handler state: 0 START, 1 INGAME, 2 WINGAME, 3 LOSTGAME
//   word_mask     word ROM data; valid one cycle after word_idx changes
//   word_idx      word ROM address
//   mask          registered word mask for the handler
//   load          one-cycle load strobe to the handler (registered)
//   load_x        key code accompanying load, 0 whenever load is low
//   used_letters  letters already issued this round
//   score         rounds won since reset, saturating at 255
//   busy          high whenever the sequencer is not idle
//   round_done    one-cycle pulse when the result hold expires
// -----------------------------------------------------------------------------
module round_sequencer #(
    parameter int WORD_COUNT  = 16,
    parameter int IDX_W       = 4,
    parameter int HOLD_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    input  logic [1:0]       game_state,
    input  logic [25:0]      word_mask,
    output logic [IDX_W-1:0] word_idx,
    output logic [25:0]      mask,
    output logic             load,
    output logic [4:0]       load_x,
    output logic [25:0]      used_letters,
    output logic [7:0]       score,
    output logic             busy,
    output logic             round_done
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  FREE_LAST = IDX_W'(WORD_COUNT - 1);
    localparam logic [4:0]        KEY_START = 5'd26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_PLAY,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  free_q, free_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [25:0]       mask_q, mask_d;
    logic [25:0]       used_q, used_d;
    logic [7:0]        score_q, score_d;
    logic [4:0]        letter_q, letter_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              load_q, load_d;
    logic [4:0]        load_x_q, load_x_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            free_q     <= '0;
            word_idx_q <= '0;
            mask_q     <= '0;
            used_q     <= '0;
            score_q    <= '0;
            letter_q   <= '0;
            hold_q     <= '0;
            load_q     <= 1'b0;
            load_x_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            free_q     <= free_d;
            word_idx_q <= word_idx_d;
            mask_q     <= mask_d;
            used_q     <= used_d;
            score_q    <= score_d;
            letter_q   <= letter_d;
            hold_q     <= hold_d;
            load_q     <= load_d;
            load_x_q   <= load_x_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        free_d     = (free_q == FREE_LAST) ? '0 : free_q + 1'b1;
        word_idx_d = word_idx_q;
        mask_d     = mask_q;
        used_d     = used_q;
        score_d    = score_q;
        letter_d   = letter_q;
        hold_d     = hold_q;
        // Strobes default low so load_x can never leak a stale code.
        load_d     = 1'b0;
        load_x_d   = '0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_valid && key_code == KEY_START) begin
                    word_idx_d = free_q;
                    state_d    = S_SELECT;
                end
            end
            // One cycle for the ROM to present the new word.
            S_SELECT: state_d = S_ARM;
            S_ARM: begin
                mask_d   = word_mask;
                used_d   = '0;
                load_d   = 1'b1;
                load_x_d = KEY_START;
                state_d  = S_PLAY;
            end
            S_PLAY: begin
                // Game end outranks any key in the same cycle.
                if (game_state == 2'd2) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end else if (game_state == 2'd3) begin
                    hold_d  = '0;
                    state_d = S_HOLD;
                end else if (key_valid && key_code <= 5'd25 && !used_q[key_code]) begin
                    used_d[key_code] = 1'b1;
                    letter_d         = key_code;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                load_d   = 1'b1;
                load_x_d = letter_q;
                state_d  = S_WAIT;
            end
            // Settle cycle for the handler; keys here are lost by design.
            S_WAIT: state_d = S_PLAY;
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    done_d  = 1'b1;
                    hold_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign word_idx     = word_idx_q;
    assign mask         = mask_q;
    assign load         = load_q;
    assign load_x       = load_x_q;
    assign used_letters = used_q;
    assign score        = score_q;
    assign busy         = (state_q != S_IDLE);
    assign round_done   = done_q;

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
//
// Directed bench for round_sequencer. Stimulus pushes the expected load /
// round_done events into a queue; a monitor on the falling edge pops and
// checks them whenever the DUT raises load or round_done.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

    localparam int K_START  = 0;
    localparam int K_LETTER = 1;
    localparam int K_DONE   = 2;

    typedef struct {
        int          kind;
        logic [4:0]  x;
        logic [3:0]  idx;
        logic [25:0] used;
        logic [7:0]  score;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic [1:0]  game_state = '0;
    logic [25:0] word_mask = '0;
    logic [3:0]  word_idx;
    logic [25:0] mask;
    logic        load;
    logic [4:0]  load_x;
    logic [25:0] used_letters;
    logic [7:0]  score;
    logic        busy;
    logic        round_done;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];
    int tb_cyc;
    logic [3:0]  cur_idx;
    logic [25:0] used_model;
    int score_model;

    round_sequencer #(.WORD_COUNT(16), .IDX_W(4), .HOLD_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .game_state(game_state), .word_mask(word_mask), .word_idx(word_idx),
        .mask(mask), .load(load), .load_x(load_x), .used_letters(used_letters),
        .score(score), .busy(busy), .round_done(round_done)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] rom(input logic [3:0] i);
        logic [31:0] v;
        v = ({28'd0, i} * 32'h0013_57A1) ^ 32'h02A5_5A5A;
        return v[25:0];
    endfunction

    // Word ROM with one-cycle registered read.
    always @(posedge clk) word_mask <= rom(word_idx);

    // Independent model of the free-running word counter.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: checks every load / round_done event against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (load) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", {27'd0, load_x}, 32'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("load_kind", (e.kind == K_DONE) ? 32'd1 : 32'd0, 32'd0);
                    chk("load_x", {27'd0, load_x}, {27'd0, e.x});
                    chk("load_used", {6'd0, used_letters}, {6'd0, e.used});
                    chk("load_mask", {6'd0, mask}, {6'd0, rom(e.idx)});
                    if (e.kind == K_START) begin
                        chk("start_idx", {28'd0, word_idx}, {28'd0, e.idx});
                        chk("start_busy", {31'd0, busy}, 32'd1);
                    end
                    $display("[TB] load x=%0d used=0x%0h mask=0x%0h", load_x, used_letters, mask);
                end
            end else begin
                chk("load_x_idle", {27'd0, load_x}, 32'd0);
            end
            if (round_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_kind", e.kind, K_DONE);
                    chk("done_score", {24'd0, score}, {24'd0, e.score});
                    chk("done_busy", {31'd0, busy}, 32'd0);
                    $display("[TB] round_done score=%0d", score);
                end
            end
        end
    end

    // Drive a key for one cycle starting at a falling edge.
    task automatic pulse_key(input logic [4:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic send_key(input logic [4:0] code);
        pulse_key(code);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_letter(input logic [4:0] code);
        exp_t e;
        used_model[code] = 1'b1;
        e = '{K_LETTER, code, cur_idx, used_model, 8'd0};
        exp_q.push_back(e);
        send_key(code);
    endtask

    // Returns in PLAY, at the falling edge where the next key may be driven.
    task automatic do_start();
        exp_t e;
        cur_idx    = 4'(tb_cyc % 16);
        used_model = '0;
        e = '{K_START, 5'd26, cur_idx, 26'd0, 8'd0};
        exp_q.push_back(e);
        pulse_key(5'd26);
        chk("word_idx", {28'd0, word_idx}, {28'd0, cur_idx});
        repeat (2) @(negedge clk);
    endtask

    task automatic push_done();
        exp_t e;
        e = '{K_DONE, 5'd0, cur_idx, used_model, 8'(score_model)};
        exp_q.push_back(e);
    endtask

    // Waits for round_done, expecting it after exp_n further falling edges.
    task automatic wait_done(input int exp_n);
        int n;
        n = 0;
        while (!round_done && n < exp_n + 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_len", n, exp_n);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic do_win();
        score_model = (score_model < 255) ? score_model + 1 : 255;
        push_done();
        game_state = 2'd2;
        @(negedge clk);
        game_state = 2'd0;
        wait_done(100);
    endtask

    initial begin
        score_model = 0;
        used_model  = '0;
        cur_idx     = '0;
        repeat (3) @(negedge clk);
        chk("rst_word_idx", {28'd0, word_idx}, 32'd0);
        chk("rst_mask", {6'd0, mask}, 32'd0);
        chk("rst_used", {6'd0, used_letters}, 32'd0);
        chk("rst_score", {24'd0, score}, 32'd0);
        chk("rst_load", {31'd0, load}, 32'd0);
        chk("rst_round_done", {31'd0, round_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Start while the free counter reads 5.
        repeat (5) @(negedge clk);
        do_start();
        chk("start_idx5", {28'd0, cur_idx}, 32'd5);
        chk("busy_play", {31'd0, busy}, 32'd1);

        // Repeated E gives a single load.
        send_letter(5'd4);
        send_key(5'd4);
        chk("used_E", {6'd0, used_letters}, 32'h10);

        // Start and ignored codes produce nothing.
        send_key(5'd26);
        send_key(5'd30);
        chk("used_after_ign", {6'd0, used_letters}, 32'h10);
        chk("busy_after_ign", {31'd0, busy}, 32'd1);

        // A key landing in WAIT is dropped.
        used_model[1] = 1'b1;
        begin
            exp_t e;
            e = '{K_LETTER, 5'd1, cur_idx, used_model, 8'd0};
            exp_q.push_back(e);
        end
        pulse_key(5'd1);
        @(negedge clk);
        pulse_key(5'd2);
        chk("used_wait_drop", {6'd0, used_letters}, 32'h12);
        send_letter(5'd2);

        // Win with a simultaneous key: key dropped, score 1.
        score_model = 1;
        push_done();
        game_state = 2'd2;
        key_valid  = 1'b1;
        key_code   = 5'd7;
        @(negedge clk);
        game_state = 2'd0;
        key_valid  = 1'b0;
        key_code   = '0;
        chk("score_win1", {24'd0, score}, 32'd1);
        chk("used_no_H", {6'd0, used_letters}, 32'h16);
        wait_done(100);

        // Loss, with a start key ignored during the hold.
        do_start();
        send_letter(5'd9);
        push_done();
        game_state = 2'd3;
        @(negedge clk);
        game_state = 2'd0;
        chk("score_lose", {24'd0, score}, 32'd1);
        repeat (20) @(negedge clk);
        pulse_key(5'd26);
        wait_done(79);

        // New round clears used letters, then win up to saturation.
        for (int r = 0; r < 255; r++) begin
            do_start();
            if (r == 0) chk("used_cleared", {6'd0, used_letters}, 32'd0);
            do_win();
        end
        chk("score_sat", {24'd0, score}, 32'd255);

        // Reset mid-PLAY clears everything at once.
        do_start();
        send_letter(5'd3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_score", {24'd0, score}, 32'd0);
        chk("mid_rst_used", {6'd0, used_letters}, 32'd0);
        chk("mid_rst_mask", {6'd0, mask}, 32'd0);
        chk("mid_rst_idx", {28'd0, word_idx}, 32'd0);
        chk("mid_rst_load", {26'd0, load, load_x}, 32'd0);
        chk("mid_rst_busy", {30'd0, busy, round_done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
